// File: rtl/aes_pkg.sv
// aes_pkg
// Shared constants and helpers for the sequential AES-128 key schedule.
// Contents: default round-key count, FSM state encodings, the AES S-box
// (sbox) and the round constant lookup (rcon_de).
// No ports.
package aes_pkg;

  localparam int NUM_RODADAS_PADRAO = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TAB = {
    256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TAB[2047 - 8 * int'(x) -: 8];
  endfunction

  // Round k (1..10) uses RCON[k-1]; anything else yields 0.
  function automatic logic [7:0] rcon_de(input logic [3:0] k);
    logic [7:0] r;
    case (k)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/expande_chave_seq_if.sv
// expande_chave_seq_if
// Bundles the key-schedule control, streaming and read-port signals.
//   start, chave[127:0]      key load request and cipher key
//   busy, done, chave_valida expansion status
//   rk_valid, rk_idx, rk_data streamed round keys
//   rd_idx, rd_chave         random read port into the key file
// master: the side that loads keys and reads results; slave: the expander.
interface expande_chave_seq_if;
  logic         start;
  logic [127:0] chave;
  logic         busy;
  logic         done;
  logic         chave_valida;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [3:0]   rd_idx;
  logic [127:0] rd_chave;

  modport master (
    output start, chave, rd_idx,
    input  busy, done, chave_valida, rk_valid, rk_idx, rk_data, rd_chave
  );

  modport slave (
    input  start, chave, rd_idx,
    output busy, done, chave_valida, rk_valid, rk_idx, rk_data, rd_chave
  );
endinterface

// File: rtl/funcao_g_comb.sv
// funcao_g_comb
// Combinational AES key-schedule g-function: RotWord, SubWord, then XOR of
// the round constant into the leading byte.
//   palavra[31:0]  in   last word (w3) of the previous round key
//   rodada[3:0]    in   round being produced (1..10), selects RCON
//   saida[31:0]    out  g(palavra)
module funcao_g_comb
  import aes_pkg::*;
(
  input  logic [31:0] palavra,
  input  logic [3:0]  rodada,
  output logic [31:0] saida
);

  // RotWord moves the leading byte to the end: b0 b1 b2 b3 -> b1 b2 b3 b0.
  always_comb begin
    saida = {sbox(palavra[23:16]) ^ rcon_de(rodada),
             sbox(palavra[15:8]),
             sbox(palavra[7:0]),
             sbox(palavra[31:24])};
  end

endmodule

// File: rtl/expande_chave_seq.sv
// expande_chave_seq
// Sequential AES-128 key expansion: one round key per clock through a single
// shared g-function, all keys kept in a flop-based key file.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset, clears state and key file
//   bus    slave side of expande_chave_seq_if (start/chave in, status,
//          round-key stream and 1-cycle-latency read port out)
module expande_chave_seq
  import aes_pkg::*;
#(
  parameter int NUM_RODADAS = NUM_RODADAS_PADRAO
) (
  input  logic             clk,
  input  logic             rst_n,
  expande_chave_seq_if.slave bus
);

  localparam logic [3:0] ULTIMA = 4'(NUM_RODADAS);

  logic [0:0]   estado;
  logic [3:0]   rodada;
  logic [127:0] rk [0:NUM_RODADAS];
  logic         done_r;
  logic         valida_r;
  logic         rk_valid_r;
  logic [3:0]   rk_idx_r;
  logic [127:0] rk_data_r;
  logic [127:0] rd_chave_r;

  logic [3:0]   anterior;
  logic [127:0] rk_ant;
  logic [127:0] rk_novo;
  logic [31:0]  t;
  logic [31:0]  w0n, w1n, w2n, w3n;

  // Previous key feeds the g-function; guarded so an idle counter value
  // never indexes past the file.
  always_comb begin
    anterior = rodada - 4'd1;
    rk_ant   = '0;
    if (anterior <= ULTIMA) rk_ant = rk[anterior];
  end

  funcao_g_comb u_g (
    .palavra (rk_ant[31:0]),
    .rodada  (rodada),
    .saida   (t)
  );

  always_comb begin
    w0n     = rk_ant[127:96] ^ t;
    w1n     = rk_ant[95:64]  ^ w0n;
    w2n     = rk_ant[63:32]  ^ w1n;
    w3n     = rk_ant[31:0]   ^ w2n;
    rk_novo = {w0n, w1n, w2n, w3n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= ST_IDLE;
      rodada     <= '0;
      done_r     <= 1'b0;
      valida_r   <= 1'b0;
      rk_valid_r <= 1'b0;
      rk_idx_r   <= '0;
      rk_data_r  <= '0;
      rd_chave_r <= '0;
      for (int i = 0; i <= NUM_RODADAS; i++) rk[i] <= '0;
    end else begin
      done_r     <= 1'b0;
      rk_valid_r <= 1'b0;

      if ((bus.rd_idx <= ULTIMA)) rd_chave_r <= rk[bus.rd_idx];
      else                        rd_chave_r <= '0;

      case (estado)
        ST_IDLE: begin
          if (bus.start) begin
            rk[0]    <= bus.chave;
            rodada   <= 4'd1;
            valida_r <= 1'b0;
            estado   <= ST_RUN;
          end
        end
        default: begin
          rk[rodada] <= rk_novo;
          rk_valid_r <= 1'b1;
          rk_idx_r   <= rodada;
          rk_data_r  <= rk_novo;
          rodada     <= rodada + 4'd1;
          if (rodada == ULTIMA) begin
            estado   <= ST_IDLE;
            done_r   <= 1'b1;
            valida_r <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy         = (estado == ST_RUN);
  assign bus.done         = done_r;
  assign bus.chave_valida = valida_r;
  assign bus.rk_valid     = rk_valid_r;
  assign bus.rk_idx       = rk_idx_r;
  assign bus.rk_data      = rk_data_r;
  assign bus.rd_chave     = rd_chave_r;

endmodule

// File: tb/tb_expande_chave_seq.sv
// tb_expande_chave_seq
// Scoreboard bench for expande_chave_seq: the driver pushes expected stream
// entries, done cycles and read results into queues; a monitor on the
// falling edge pops and compares whenever the DUT presents an output.
module tb_expande_chave_seq;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
    logic         chk;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   ciclo;
  logic rd_chk;
  logic rd_chk_q;

  exp_t         sq[$];
  int           dq[$];
  logic [127:0] rq[$];

  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [127:0] zero_rk1 = 128'h62636363626363636263636362636363;

  expande_chave_seq_if bus ();

  expande_chave_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ciclo    <= ciclo + 1;
    rd_chk_q <= rd_chk;
  end

  task automatic chk(input string nome, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nome, got, exp);
    end
  endtask

  task automatic falha(input string nome);
    checks++;
    errors++;
    $display("FAIL %s got unexpected event expected none", nome);
  endtask

  // Monitor: compares whatever the DUT presents on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (rst_n) begin
      if (bus.rk_valid) begin
        if (sq.size() == 0) falha("stream_extra");
        else begin
          e = sq.pop_front();
          chk("stream_idx", 128'(bus.rk_idx), 128'(e.idx));
          if (e.chk) chk("stream_data", bus.rk_data, e.data);
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) falha("done_extra");
        else begin
          d = dq.pop_front();
          chk("done_cycle", 128'(ciclo), 128'(d));
        end
      end
      if (rd_chk_q) begin
        if (rq.size() == 0) falha("rd_extra");
        else chk("rd_chave", bus.rd_chave, rq.pop_front());
      end
    end
  end

  task automatic passo();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fips();
    exp_t e;
    for (int k = 1; k <= 10; k++) begin
      e.idx  = 4'(k);
      e.data = fips_rk[k];
      e.chk  = 1'b1;
      sq.push_back(e);
    end
    dq.push_back(ciclo + 11);
  endtask

  task automatic push_zero();
    exp_t e;
    for (int k = 1; k <= 10; k++) begin
      e.idx  = 4'(k);
      e.data = zero_rk1;
      e.chk  = (k == 1);
      sq.push_back(e);
    end
    dq.push_back(ciclo + 11);
  endtask

  task automatic ler(input logic [3:0] idx, input logic [127:0] exp);
    bus.rd_idx = idx;
    rd_chk     = 1'b1;
    rq.push_back(exp);
    passo();
    rd_chk     = 1'b0;
  endtask

  task automatic drenar();
    int n;
    n = 0;
    while ((sq.size() != 0 || dq.size() != 0 || rq.size() != 0) && n < 40) begin
      passo();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", sq.size() + dq.size() + rq.size());
      sq.delete();
      dq.delete();
      rq.delete();
    end
  endtask

  task automatic saidas_zero(input string nome);
    chk({nome, "_busy"},     128'(bus.busy), 128'd0);
    chk({nome, "_done"},     128'(bus.done), 128'd0);
    chk({nome, "_valida"},   128'(bus.chave_valida), 128'd0);
    chk({nome, "_rk_valid"}, 128'(bus.rk_valid), 128'd0);
    chk({nome, "_rk_idx"},   128'(bus.rk_idx), 128'd0);
    chk({nome, "_rk_data"},  bus.rk_data, 128'd0);
    chk({nome, "_rd_chave"}, bus.rd_chave, 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    ciclo     = 0;
    rd_chk    = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.chave = '0;
    bus.rd_idx = 4'd0;
    repeat (3) passo();
    saidas_zero("reset");
    rst_n = 1'b1;
    passo();

    // FIPS-197 key; a second start mid-run with another key must be ignored.
    bus.start = 1'b1;
    bus.chave = fips_rk[0];
    push_fips();
    passo();
    bus.start = 1'b0;
    chk("busy_run", 128'(bus.busy), 128'd1);
    repeat (3) passo();
    bus.start = 1'b1;
    bus.chave = {4{32'hdeadbeef}};
    passo();
    bus.start = 1'b0;
    drenar();
    chk("valida_after", 128'(bus.chave_valida), 128'd1);
    chk("busy_after", 128'(bus.busy), 128'd0);

    ler(4'd0, fips_rk[0]);
    ler(4'd10, fips_rk[10]);
    ler(4'd11, 128'd0);
    ler(4'd15, 128'd0);
    ler(4'd5, fips_rk[5]);
    passo();
    drenar();

    // Back-to-back: new start issued while done is high.
    bus.start = 1'b1;
    bus.chave = fips_rk[0];
    push_fips();
    passo();
    bus.start = 1'b0;
    repeat (10) passo();
    chk("b2b_done", 128'(bus.done), 128'd1);
    bus.start = 1'b1;
    bus.chave = '0;
    push_zero();
    passo();
    bus.start = 1'b0;
    chk("b2b_valida_drop", 128'(bus.chave_valida), 128'd0);
    chk("b2b_busy", 128'(bus.busy), 128'd1);
    drenar();
    ler(4'd1, zero_rk1);
    ler(4'd0, 128'd0);
    passo();
    drenar();

    // Reset in the middle of an expansion.
    bus.start = 1'b1;
    bus.chave = fips_rk[0];
    push_fips();
    passo();
    bus.start = 1'b0;
    repeat (4) passo();
    rst_n = 1'b0;
    #1;
    saidas_zero("midrst");
    sq.delete();
    dq.delete();
    passo();
    rst_n = 1'b1;
    passo();
    ler(4'd10, 128'd0);
    passo();
    drenar();

    bus.start = 1'b1;
    bus.chave = fips_rk[0];
    push_fips();
    passo();
    bus.start = 1'b0;
    drenar();
    ler(4'd10, fips_rk[10]);
    ler(4'd1, fips_rk[1]);
    passo();
    drenar();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
